// File: rtl/keccak_byte_packer.sv
// Packs a valid/ready byte stream into the keccak core's 32-bit word interface.
// It emits partial final words, and adds a zero terminator word after messages whose length is a multiple of 4.
module keccak_byte_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             byte_last,
  input  logic             empty_last,
  output logic             byte_ready,
  output logic [31:0]      word_out,
  output logic             word_valid,
  output logic             word_last,
  output logic [1:0]       word_bytes,
  input  logic             buffer_full,
  output logic [CNT_W-1:0] msg_bytes,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_TERM = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MSG_MAX = '1;
  localparam logic [CNT_W-1:0] MSG_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [1:0]       r_cnt;
  logic             r_pending_term;
  logic             r_in_msg;
  logic             r_byte_ready;
  logic [31:0]      r_word_out;
  logic             r_word_valid;
  logic             r_word_last;
  logic [1:0]       r_word_bytes;
  logic [CNT_W-1:0] r_msg_bytes;

  logic [31:0]      w_next_word;
  logic             w_byte_acc;
  logic             w_empty_acc;
  logic             w_word_xfer;
  logic             w_word_done;
  logic             w_short_last;
  logic [CNT_W-1:0] w_msg_next;

  // Lane cnt takes the incoming byte; lanes beyond it are still zero in r_acc.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_next_word[31-8*gi -: 8] = (r_cnt == 2'(gi)) ? byte_in : r_acc[31-8*gi -: 8];
    end
  endgenerate

  assign w_byte_acc   = byte_valid && r_byte_ready;
  assign w_empty_acc  = r_byte_ready && empty_last && !byte_valid && (r_cnt == 2'd0);
  assign w_word_xfer  = r_word_valid && !buffer_full;
  assign w_word_done  = (r_cnt == 2'd3) || byte_last;
  assign w_short_last = byte_last && (r_cnt != 2'd3);
  assign w_msg_next   = !r_in_msg ? MSG_ONE :
                        (r_msg_bytes == MSG_MAX) ? r_msg_bytes : r_msg_bytes + MSG_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_FILL;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_pending_term <= 1'b0;
      r_in_msg       <= 1'b0;
      r_byte_ready   <= 1'b1;
      r_word_out     <= '0;
      r_word_valid   <= 1'b0;
      r_word_last    <= 1'b0;
      r_word_bytes   <= '0;
      r_msg_bytes    <= '0;
    end else begin
      if (w_byte_acc) begin
        r_msg_bytes <= w_msg_next;
        r_in_msg    <= !byte_last;
      end
      case (r_state)
        ST_FILL: begin
          if (w_byte_acc) begin
            r_acc <= w_next_word;
            r_cnt <= r_cnt + 2'd1;
            if (w_word_done) begin
              r_state        <= ST_HOLD;
              r_byte_ready   <= 1'b0;
              r_word_out     <= w_next_word;
              r_word_valid   <= 1'b1;
              r_word_last    <= w_short_last;
              r_word_bytes   <= w_short_last ? r_cnt + 2'd1 : 2'd0;
              r_pending_term <= byte_last && (r_cnt == 2'd3);
            end
          end else if (w_empty_acc) begin
            r_state      <= ST_HOLD;
            r_byte_ready <= 1'b0;
            r_word_out   <= '0;
            r_word_valid <= 1'b1;
            r_word_last  <= 1'b1;
            r_word_bytes <= 2'd0;
          end
        end
        ST_HOLD: begin
          if (w_word_xfer) begin
            r_acc <= '0;
            r_cnt <= '0;
            if (r_pending_term) begin
              // Full final word needs a zero-length word to close the message.
              r_state        <= ST_TERM;
              r_pending_term <= 1'b0;
              r_word_out     <= '0;
              r_word_last    <= 1'b1;
              r_word_bytes   <= 2'd0;
            end else begin
              r_state      <= ST_FILL;
              r_byte_ready <= 1'b1;
              r_word_valid <= 1'b0;
            end
          end
        end
        ST_TERM: begin
          if (w_word_xfer) begin
            r_state      <= ST_FILL;
            r_byte_ready <= 1'b1;
            r_word_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_FILL;
          r_byte_ready <= 1'b1;
          r_word_valid <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign word_last  = r_word_last;
  assign word_bytes = r_word_bytes;
  assign msg_bytes  = r_msg_bytes;
  assign busy       = (r_cnt != 2'd0) || (r_state != ST_FILL);

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Random and directed checks of keccak_byte_packer against a message-level queue model.
module tb_keccak_byte_packer;
  localparam int CW   = 5;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    byte_in;
  logic          byte_valid, byte_last, empty_last;
  logic          byte_ready;
  logic [31:0]   word_out;
  logic          word_valid, word_last;
  logic [1:0]    word_bytes;
  logic          buffer_full;
  logic [CW-1:0] msg_bytes;
  logic          busy;

  keccak_byte_packer #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .empty_last(empty_last), .byte_ready(byte_ready),
    .word_out(word_out), .word_valid(word_valid), .word_last(word_last),
    .word_bytes(word_bytes), .buffer_full(buffer_full), .msg_bytes(msg_bytes),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        l;
    logic [1:0]  n;
  } word_t;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;
  bit bf_rand = 0;

  // Model: bytes of the word being built, words owed downstream, message byte count.
  logic [7:0] m_part[$];
  word_t      m_q[$];
  word_t      log_q[$];
  int         m_msg = 0;
  bit         m_new = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic word_t pack_part();
    word_t r;
    r.w = 32'h0;
    for (int i = 0; i < m_part.size(); i++) r.w |= 32'(m_part[i]) << (24 - 8 * i);
    r.l = 1'b0;
    r.n = 2'd0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_part.delete();
      m_q.delete();
      m_msg = 0;
      m_new = 1;
    end else begin
      bit    rdy;
      word_t t;
      rdy = (m_q.size() == 0);
      if (!rdy && !buffer_full) void'(m_q.pop_front());
      if (rdy && byte_valid) begin
        m_msg = m_new ? 1 : (m_msg < MAXV ? m_msg + 1 : MAXV);
        m_new = byte_last;
        m_part.push_back(byte_in);
        if (m_part.size() == 4) begin
          m_q.push_back(pack_part());
          m_part.delete();
          if (byte_last) m_q.push_back('{32'h0, 1'b1, 2'd0});
        end else if (byte_last) begin
          t = pack_part();
          t.l = 1'b1;
          t.n = 2'(m_part.size());
          m_q.push_back(t);
          m_part.delete();
        end
      end else if (rdy && empty_last && m_part.size() == 0) begin
        m_q.push_back('{32'h0, 1'b1, 2'd0});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byte_ready", {31'h0, byte_ready}, {31'h0, m_q.size() == 0});
      chk("word_valid", {31'h0, word_valid}, {31'h0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("word_out", word_out, m_q[0].w);
        chk("word_last", {31'h0, word_last}, {31'h0, m_q[0].l});
        chk("word_bytes", {30'h0, word_bytes}, {30'h0, m_q[0].n});
      end
      chk("busy", {31'h0, busy}, {31'h0, (m_q.size() != 0) || (m_part.size() != 0)});
      chk("msg_bytes", 32'(msg_bytes), 32'(m_msg));
      if (word_valid && !buffer_full) log_q.push_back('{word_out, word_last, word_bytes});
    end
  end

  always @(posedge clk) begin
    #1;
    if (bf_rand) buffer_full = ($urandom_range(0, 2) == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, output int n);
    bit rdy;
    n = 0;
    byte_in = b; byte_valid = 1'b1; byte_last = last;
    do begin
      @(negedge clk);
      rdy = byte_ready;
      tick();
      n++;
    end while (!rdy && n < 300);
    if (!rdy) chk("byte_accept_timeout", 32'(n), 32'(0));
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last);
    int n;
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1), n);
  endtask

  task automatic drain();
    int n = 0;
    while (m_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (m_q.size() != 0) chk("drain_timeout", 32'(m_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_log(input int idx, input logic [31:0] w, input logic l, input logic [1:0] n);
    if (idx >= log_q.size()) begin
      chk("log_missing", 32'(log_q.size()), 32'(idx + 1));
    end else begin
      chk("log_word", log_q[idx].w, w);
      chk("log_last", {31'h0, log_q[idx].l}, {31'h0, l});
      chk("log_bytes", {30'h0, log_q[idx].n}, {30'h0, n});
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int len;
    byte_in = 8'h0; byte_valid = 1'b0; byte_last = 1'b0; empty_last = 1'b0;
    buffer_full = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_ready", {31'h0, byte_ready}, 32'h1);
    chk("rst_msg", 32'(msg_bytes), 32'h0);
    tick();

    log_q.delete();
    send_str("Hello, world!", 1);
    drain();
    chk("hello_count", 32'(log_q.size()), 32'd4);
    chk_log(0, 32'h48656c6c, 1'b0, 2'd0);
    chk_log(1, 32'h6f2c2077, 1'b0, 2'd0);
    chk_log(2, 32'h6f726c64, 1'b0, 2'd0);
    chk_log(3, 32'h21000000, 1'b1, 2'd1);
    chk("hello_msg", 32'(msg_bytes), 32'd13);

    log_q.delete();
    send_str("Hell", 1);
    drain();
    repeat (3) tick();
    chk("hell_count", 32'(log_q.size()), 32'd2);
    chk_log(0, 32'h48656c6c, 1'b0, 2'd0);
    chk_log(1, 32'h00000000, 1'b1, 2'd0);

    log_q.delete();
    empty_last = 1'b1;
    tick();
    empty_last = 1'b0;
    drain();
    repeat (3) tick();
    chk("empty_count", 32'(log_q.size()), 32'd1);
    chk_log(0, 32'h00000000, 1'b1, 2'd0);
    chk("empty_msg", 32'(msg_bytes), 32'd4);

    log_q.delete();
    send_str("The ", 0);
    buffer_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bf_hold_word", word_out, 32'h54686520);
      chk("bf_hold_ready", {31'h0, byte_ready}, 32'h0);
    end
    tick();
    buffer_full = 1'b0;
    send_byte("q", 1, n);
    chk("bf_q_cycles", 32'(n), 32'd2);
    drain();
    chk("bf_count", 32'(log_q.size()), 32'd2);
    chk_log(0, 32'h54686520, 1'b0, 2'd0);
    chk_log(1, 32'h71000000, 1'b1, 2'd1);
    chk("bf_msg", 32'(msg_bytes), 32'd5);

    log_q.delete();
    send_str("12", 0);
    do_reset();
    @(negedge clk);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_valid", {31'h0, word_valid}, 32'h0);
    tick();
    send_str("90", 1);
    drain();
    chk("rst_count", 32'(log_q.size()), 32'd1);
    chk_log(0, 32'h39300000, 1'b1, 2'd2);
    chk("rst_msg", 32'(msg_bytes), 32'd2);

    log_q.delete();
    empty_last = 1'b1;
    send_byte("x", 1, n);
    empty_last = 1'b0;
    drain();
    repeat (3) tick();
    chk("race_count", 32'(log_q.size()), 32'd1);
    chk_log(0, 32'h78000000, 1'b1, 2'd1);

    for (int i = 0; i < 35; i++) send_byte(8'(i), i == 34, n);
    drain();
    chk("sat_msg", 32'(msg_bytes), 32'(MAXV));

    bf_rand = 1;
    for (int m = 0; m < 150; m++) begin
      len = $urandom_range(0, 40);
      if (len == 0) begin
        empty_last = 1'b1;
        tick();
        empty_last = 1'b0;
      end else begin
        for (int i = 0; i < len; i++) begin
          if (len > 2 && i == len / 2 && $urandom_range(0, 19) == 0) begin
            do_reset();
            break;
          end
          repeat ($urandom_range(0, 2)) begin
            empty_last = ((i % 4) != 0) && ($urandom_range(0, 1) == 1);
            tick();
            empty_last = 1'b0;
          end
          empty_last = ($urandom_range(0, 3) == 0);
          send_byte(8'($urandom), i == len - 1, n);
          empty_last = 1'b0;
        end
      end
      drain();
    end
    bf_rand = 0;
    tick();
    buffer_full = 1'b0;
    drain();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/keccak_byte_packer.md
Name: keccak_byte_packer

Overview:
Upstream feeder for the keccak core. It takes a byte stream with a valid/ready handshake and packs it into the core's 32-bit word interface. That interface uses in, in_ready, is_last and byte_num, with buffer_full as backpressure. The block handles partial final words, and emits the extra zero terminator word the core requires when a message length is a multiple of 4.

Parameters:
CNT_W, 16, width of the per-message byte counter msg_bytes (saturating).

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
byte_in  input  8  message byte.
byte_valid  input  1  byte_in valid.
byte_last  input  1  qualifies byte_valid; marks the final byte of the message.
empty_last  input  1  request to terminate a zero-length message.
byte_ready  output  1  packer can accept a byte this cycle.
word_out  output  32  to keccak in; first byte of the word in [31:24].
word_valid  output  1  to keccak in_ready.
word_last  output  1  to keccak is_last.
word_bytes  output  2  to keccak byte_num.
buffer_full  input  1  from keccak; backpressure.
msg_bytes  output  CNT_W  bytes accepted in the current or most recent message.
busy  output  1  high while a message is partially packed or a word is pending.

Behaviour:
- Byte handshake: a byte transfers on a posedge with byte_valid && byte_ready.
- Word handshake: a word transfers on a posedge with word_valid && !buffer_full.
- States:
  - FILL: accumulating bytes. byte_ready=1, word_valid=0.
  - HOLD: word presented. byte_ready=0.
  - TERM: zero terminator word presented. byte_ready=0.
- Accumulator and byte placement:
  - Accumulator acc[31:0] with lane counter cnt[1:0].
  - Byte k of a word goes to acc[31-8k -: 8].
  - Unused lanes of a final partial word are driven 0.
- FILL, byte accepted with cnt<3 and !byte_last: store the byte, cnt++.
- FILL, byte accepted with cnt==3: word_out = completed word, word_last=0, word_bytes=0, go to HOLD. If byte_last is also set, a pending_term flag is set.
- FILL, byte accepted with byte_last and cnt<3: word_out = partial word, word_last=1, word_bytes=cnt+1 (1..3), go to HOLD.
- FILL, empty_last with cnt==0 and !byte_valid: word_out=0, word_last=1, word_bytes=0, go to HOLD.
- FILL, empty_last ignored cases:
  - when cnt!=0;
  - when byte_valid is high in the same cycle (the byte wins).
- HOLD, on word transfer:
  - pending_term set: go to TERM (word_out=0, word_last=1, word_bytes=0) and clear pending_term.
  - otherwise: go to FILL with cnt=0 and acc=0.
- TERM, on word transfer: go to FILL.
- buffer_full high: word_out, word_last and word_bytes are held stable; no bytes are accepted; nothing is dropped or duplicated.
- Latency: word_valid rises the cycle after the byte that completes the word is accepted.
- Minimum cost: 5 cycles per 4 bytes with buffer_full low; a multiple-of-4 message adds 1 extra cycle for TERM.
- msg_bytes:
  - increments on each byte accepted;
  - saturates at 2^CNT_W-1;
  - holds its final value after the last byte;
  - loads 1 on the first byte of the next message.
- busy = (cnt!=0) || state!=FILL.
- Reset values: state FILL, cnt=0, acc=0, pending_term=0, word_out=0, word_valid=0, word_last=0, word_bytes=0, msg_bytes=0, busy=0. byte_ready=1 from the first cycle after reset.
- Reset mid-message or with a word pending discards all state. No partial word is emitted afterwards.
- Downstream keccak reset between messages is the system's responsibility. The packer never asserts word_valid across a keccak reset it did not see.

Test Plan:
- "Hello, world!" (13 bytes, last on '!') -> 4 words:
  - "Hell", "o, w", "orld" with last=0, bytes=0;
  - then 0x21000000 with last=1, bytes=1;
  - msg_bytes=13.
- "Hell" (4 bytes) -> "Hell" with last=0, bytes=0, then 0x00000000 with last=1, bytes=0. Exactly 2 word transfers.
- empty_last pulse while idle -> single word 0x00000000 with last=1, bytes=0. msg_bytes unchanged.
- buffer_full high for 5 cycles while "The " is presented -> word_out="The " stable and byte_ready=0 throughout. One transfer after release; the next byte "q" is accepted on the following cycle.
- Reset after 2 bytes of "12345" -> busy=0, word_valid=0. Then "90" with last -> single word 0x39300000 with last=1, bytes=2; msg_bytes=2.
- byte_valid('x', last=1) and empty_last in the same cycle at cnt=0 -> word 0x78000000 with last=1, bytes=1. No extra empty word follows.
